// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that serialises requester transactions onto one SPI host.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_data,
    output logic                   rsp_err,
    output logic [15:0]            host_tx_data,
    output logic                   host_tx_start,
    input  logic                   host_tx_done,
    input  logic                   host_rx_valid,
    input  logic [15:0]            host_rx_data,
    output logic                   busy
);
    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CW   = IDXW + 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("spi_txn_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [15:0]         rsp_data_q, rsp_data_d;
    logic [15:0]         host_tx_data_q, host_tx_data_d;
    logic                host_tx_start_q, host_tx_start_d;
    logic                busy_q, busy_d;
    logic [IDXW-1:0]     last_grant_q, last_grant_d;
    logic [IDXW-1:0]     grant_idx_q, grant_idx_d;

    logic [15:0]         req_word [NUM_REQ];
    logic [CW-1:0]       cand [NUM_REQ];
    logic [NUM_REQ-1:0]  cand_hit;
    logic [IDXW-1:0]     pick_idx;
    logic                host_evt;

    assign host_evt = host_rx_valid | host_tx_done;

    // cand[gi] is the requester at rotation offset gi, starting just after last_grant.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [CW-1:0] sum;
        assign sum          = {1'b0, last_grant_q} + CW'(gi + 1);
        assign cand[gi]     = (sum >= CW'(NUM_REQ)) ? sum - CW'(NUM_REQ) : sum;
        assign cand_hit[gi] = req[cand[gi][IDXW-1:0]];
        assign req_word[gi] = req_data[16*gi +: 16];
    end

    always_comb begin
        pick_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) pick_idx = cand[i][IDXW-1:0];
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        rsp_err_q, rsp_err_d;
    logic        wd_expired;
    assign wd_expired = (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        rsp_valid_d     = '0;
        rsp_data_d      = rsp_data_q;
        host_tx_data_d  = host_tx_data_q;
        host_tx_start_d = 1'b0;
        last_grant_d    = last_grant_q;
        grant_idx_d     = grant_idx_q;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_cnt_d        = wd_cnt_q;
        rsp_err_d       = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|cand_hit) begin
                    state_d           = S_START;
                    grant_idx_d       = pick_idx;
                    gnt_d             = '0;
                    gnt_d[pick_idx]   = 1'b1;
                    host_tx_data_d    = req_word[pick_idx];
                    host_tx_start_d   = 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (host_evt) begin
                    state_d     = S_RESP;
                    rsp_valid_d = gnt_q;
                    rsp_data_d  = host_rx_data;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d     = S_RESP;
                    rsp_valid_d = gnt_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
`endif
            end
            S_RESP: begin
                state_d      = S_IDLE;
                gnt_d        = '0;
                last_grant_d = grant_idx_q;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            gnt_q           <= '0;
            rsp_valid_q     <= '0;
            rsp_data_q      <= '0;
            host_tx_data_q  <= '0;
            host_tx_start_q <= 1'b0;
            busy_q          <= 1'b0;
            last_grant_q    <= IDXW'(NUM_REQ - 1);
            grant_idx_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_cnt_q        <= '0;
            rsp_err_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            host_tx_data_q  <= host_tx_data_d;
            host_tx_start_q <= host_tx_start_d;
            busy_q          <= busy_d;
            last_grant_q    <= last_grant_d;
            grant_idx_q     <= grant_idx_d;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_cnt_q        <= wd_cnt_d;
            rsp_err_q       <= rsp_err_d;
`endif
        end
    end

    assign gnt           = gnt_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign host_tx_data  = host_tx_data_q;
    assign host_tx_start = host_tx_start_q;
    assign busy          = busy_q;

endmodule
